// File: rtl/traffic_phase_ctrl.sv
// Fixed-cycle traffic phase controller: GREEN -> YELLOW [-> ALLRED] -> next demanded phase.
// Optional all-red clearance state is built only when TL_ALLRED_EN is defined.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  tick,
    input  logic                  hold,
    input  logic [NUM_PHASES-1:0] veh_req,
    output logic [NUM_PHASES-1:0] grn,
    output logic [NUM_PHASES-1:0] yel,
    output logic [NUM_PHASES-1:0] red,
    output logic [2:0]            phase_idx,
    output logic                  phase_chg
);

    localparam int IDXW = $clog2(NUM_PHASES);
    localparam logic [7:0] GREEN_INIT  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] YELLOW_INIT = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] ALLRED_INIT = 8'(ALLRED_CYC - 1);
    localparam logic [NUM_PHASES-1:0] PH0_OH = NUM_PHASES'(1'b1);

    if (NUM_PHASES < 2 || NUM_PHASES > 8 || GREEN_CYC < 1 || GREEN_CYC > 255 ||
        YELLOW_CYC < 1 || YELLOW_CYC > 255 || ALLRED_CYC < 1 || ALLRED_CYC > 255) begin : g_param_check
        $error("traffic_phase_ctrl: parameter out of legal range");
    end

`ifdef TL_ALLRED_EN
    typedef enum logic [1:0] {ST_GREEN = 2'd0, ST_YELLOW = 2'd1, ST_ALLRED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_GREEN = 2'd0, ST_YELLOW = 2'd1} state_t;
`endif

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [7:0]              timer_r;
    logic [7:0]              timer_nxt_s;
    logic [2:0]              phase_r;
    logic [2:0]              phase_nxt_s;
    logic [2:0]              sel_phase_s;
    logic                    chg_nxt_s;
    logic [NUM_PHASES-1:0]   lamp_oh_s;
    logic [NUM_PHASES-1:0]   grn_nxt_s;
    logic [NUM_PHASES-1:0]   yel_nxt_s;
    logic [NUM_PHASES-1:0]   red_nxt_s;

    // Round-robin search from cur+1 wrapping back to cur; no demand at all falls back to cur+1.
    function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic [NUM_PHASES-1:0] req);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = 3'((int'(cur) + 1) % NUM_PHASES);
        found = 1'b0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = (int'(cur) + k) % NUM_PHASES;
            if (!found && req[IDXW'(idx)]) begin
                res   = 3'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Next-state, timer and phase selection; hold blocks tick entirely.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        phase_nxt_s = phase_r;
        chg_nxt_s   = 1'b0;
        sel_phase_s = next_phase(phase_r, veh_req);
        if (tick && !hold) begin
            if (timer_r != 8'd0) begin
                timer_nxt_s = timer_r - 8'd1;
            end else begin
                case (state_r)
                    ST_GREEN: begin
                        state_nxt_s = ST_YELLOW;
                        timer_nxt_s = YELLOW_INIT;
                    end
`ifdef TL_ALLRED_EN
                    ST_YELLOW: begin
                        state_nxt_s = ST_ALLRED;
                        timer_nxt_s = ALLRED_INIT;
                    end
                    ST_ALLRED: begin
                        state_nxt_s = ST_GREEN;
                        timer_nxt_s = GREEN_INIT;
                        phase_nxt_s = sel_phase_s;
                        chg_nxt_s   = 1'b1;
                    end
`else
                    ST_YELLOW: begin
                        state_nxt_s = ST_GREEN;
                        timer_nxt_s = GREEN_INIT;
                        phase_nxt_s = sel_phase_s;
                        chg_nxt_s   = 1'b1;
                    end
`endif
                    default: begin
                        state_nxt_s = ST_GREEN;
                        timer_nxt_s = GREEN_INIT;
                        phase_nxt_s = 3'd0;
                    end
                endcase
            end
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Lamp pattern for the upcoming state; every non-active phase is red.
    always_comb begin
        lamp_oh_s = PH0_OH << phase_nxt_s;
        grn_nxt_s = (state_nxt_s == ST_GREEN)  ? lamp_oh_s : {NUM_PHASES{1'b0}};
        yel_nxt_s = (state_nxt_s == ST_YELLOW) ? lamp_oh_s : {NUM_PHASES{1'b0}};
        red_nxt_s = ~(grn_nxt_s | yel_nxt_s);
    end

    // State, timer, phase and registered lamp outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_GREEN;
            timer_r   <= GREEN_INIT;
            phase_r   <= 3'd0;
            phase_chg <= 1'b0;
            grn       <= PH0_OH;
            yel       <= {NUM_PHASES{1'b0}};
            red       <= ~PH0_OH;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            phase_r   <= phase_nxt_s;
            phase_chg <= chg_nxt_s;
            grn       <= grn_nxt_s;
            yel       <= yel_nxt_s;
            red       <= red_nxt_s;
        end
    end

    assign phase_idx = phase_r;

endmodule
